// File: rtl/cpu_run_ctrl_pkg.sv
// Shared state encoding, defaults and helpers for the rv32i run controller.
package cpu_run_ctrl_pkg;

  localparam int unsigned RC_DEF_PC_W    = 32;
  localparam logic [31:0] RC_DEF_HALT_PC = 32'h0000_0100;
  localparam int unsigned RC_CYC_W       = 32;

  typedef enum logic [2:0] {
    RC_IDLE    = 3'd0,
    RC_RESET   = 3'd1,
    RC_RUN     = 3'd2,
    RC_HALT    = 3'd3,
    RC_TIMEOUT = 3'd4
  } rc_state_e;

  // Per-state control outputs, registered together from the next state.
  typedef struct packed {
    logic core_rst_n;
    logic busy;
    logic done;
  } rc_ctl_t;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int unsigned rc_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic rc_ctl_t rc_ctl_of(input rc_state_e s);
    rc_ctl_t c;
    c.core_rst_n = (s == RC_RUN) || (s == RC_HALT) || (s == RC_TIMEOUT);
    c.busy       = (s == RC_RESET) || (s == RC_RUN);
    c.done       = (s == RC_HALT) || (s == RC_TIMEOUT);
    return c;
  endfunction

endpackage

// File: rtl/run_ctrl_trace_buf.sv
// Circular PC history: writes on request, registered indexed read (0 = newest).
// DEPTH must be a power of two so the pointer wraps naturally.
module run_ctrl_trace_buf
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned  PC_W  = RC_DEF_PC_W,
  parameter int unsigned  DEPTH = 8,
  localparam int unsigned IDX_W = rc_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [PC_W-1:0]  wr_pc,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [PC_W-1:0]  rd_pc
);

  logic [PC_W-1:0]  mem_q [DEPTH];
  logic [IDX_W-1:0] wptr_q;
  logic [IDX_W-1:0] rd_addr;

  // wptr points at the next free slot, so the newest entry sits one below it.
  assign rd_addr = wptr_q - IDX_W'(1) - rd_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rd_pc  <= '0;
    end else begin
      if (clr) begin
        wptr_q <= '0;
      end else if (we) begin
        wptr_q <= wptr_q + IDX_W'(1);
      end
      rd_pc <= mem_q[rd_addr];
    end
  end

  // Storage needs no reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wptr_q] <= wr_pc;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the rv32i core: sequences core reset, counts RUN cycles,
// detects halt (PC self-loop) or timeout. PC trace enabled by RUN_CTRL_PC_TRACE_EN.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned  PC_W           = RC_DEF_PC_W,
  parameter int unsigned  RST_CYCLES     = 40,
  parameter int unsigned  STALL_CYCLES   = 8,
  parameter int unsigned  TIMEOUT_CYCLES = 500,
  parameter logic [31:0]  HALT_PC        = RC_DEF_HALT_PC,
  parameter int unsigned  TRACE_DEPTH    = 8,
  localparam int unsigned TRACE_IDX_W    = rc_cnt_w(TRACE_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clear,
  input  logic [PC_W-1:0]        ext_pc,
  output logic                   core_rst_n,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [RC_CYC_W-1:0]    cycle_cnt,
  input  logic [TRACE_IDX_W-1:0] trace_idx,
  output logic [PC_W-1:0]        trace_pc
);

  localparam int unsigned         RST_W      = rc_cnt_w(RST_CYCLES);
  localparam int unsigned         STALL_W    = rc_cnt_w(STALL_CYCLES);
  localparam logic [RST_W-1:0]    RST_LAST   = RST_W'(RST_CYCLES - 1);
  localparam logic [STALL_W-1:0]  STALL_LAST = STALL_W'(STALL_CYCLES - 1);
  localparam logic [RC_CYC_W-1:0] TMO_LAST   = RC_CYC_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PC_W-1:0]     HALT_PC_W  = PC_W'(HALT_PC);

  logic [1:0]          rst_sync_q;
  rc_state_e           state_q, state_d;
  logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [PC_W-1:0]     prev_pc_q, prev_pc_d;
  logic                pc_valid_q, pc_valid_d;
  logic [RC_CYC_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic                pass_q, pass_d;
  logic                timeout_q, timeout_d;
  rc_ctl_t             ctl_q;
  logic                pc_same;
  logic                run_clr;
  logic                trace_clr;
  logic                trace_we;

  // Reset assertion is immediate; release reaches the FSM through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RC_IDLE;
      rst_cnt_q   <= '0;
      stall_cnt_q <= '0;
      prev_pc_q   <= '0;
      pc_valid_q  <= 1'b0;
      cycle_cnt_q <= '0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      ctl_q       <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      prev_pc_q   <= prev_pc_d;
      pc_valid_q  <= pc_valid_d;
      cycle_cnt_q <= cycle_cnt_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      ctl_q       <= rc_ctl_of(state_d);
    end
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    stall_cnt_d = stall_cnt_q;
    prev_pc_d   = prev_pc_q;
    pc_valid_d  = pc_valid_q;
    cycle_cnt_d = cycle_cnt_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    run_clr     = 1'b0;
    trace_clr   = 1'b0;
    trace_we    = 1'b0;
    // The first RUN cycle only loads prev_pc, so it never counts as a stall.
    pc_same     = pc_valid_q && (ext_pc == prev_pc_q);

    case (state_q)
      RC_IDLE: begin
        run_clr = 1'b1;
        if (start) begin
          state_d   = RC_RESET;
          trace_clr = 1'b1;
        end
      end
      RC_RESET: begin
        rst_cnt_d = rst_cnt_q + RST_W'(1);
        if (rst_cnt_q == RST_LAST) begin
          state_d = RC_RUN;
        end
      end
      RC_RUN: begin
        prev_pc_d   = ext_pc;
        pc_valid_d  = 1'b1;
        trace_we    = !pc_same;
        stall_cnt_d = pc_same ? stall_cnt_q + STALL_W'(1) : '0;
        // Halt is checked first so it wins a same-cycle tie with timeout.
        if (pc_same && (stall_cnt_q == STALL_LAST)) begin
          state_d   = RC_HALT;
          pass_d    = (ext_pc == HALT_PC_W);
          timeout_d = 1'b0;
        end else if (cycle_cnt_q == TMO_LAST) begin
          state_d   = RC_TIMEOUT;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else if (cycle_cnt_q != '1) begin
          cycle_cnt_d = cycle_cnt_q + RC_CYC_W'(1);
        end
      end
      RC_HALT, RC_TIMEOUT: begin
        if (start) begin
          state_d   = RC_RESET;
          run_clr   = 1'b1;
          trace_clr = 1'b1;
        end
      end
      default: begin
        state_d = RC_IDLE;
      end
    endcase

    if (clear || !rst_sync_q[1]) begin
      state_d = RC_IDLE;
      run_clr = 1'b1;
    end

    if (run_clr) begin
      rst_cnt_d   = '0;
      stall_cnt_d = '0;
      pc_valid_d  = 1'b0;
      cycle_cnt_d = '0;
      pass_d      = 1'b0;
      timeout_d   = 1'b0;
    end
  end

  assign core_rst_n = ctl_q.core_rst_n;
  assign busy       = ctl_q.busy;
  assign done       = ctl_q.done;
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign cycle_cnt  = cycle_cnt_q;

`ifdef RUN_CTRL_PC_TRACE_EN
  run_ctrl_trace_buf #(
    .PC_W  (PC_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (trace_clr),
    .we     (trace_we),
    .wr_pc  (ext_pc),
    .rd_idx (trace_idx),
    .rd_pc  (trace_pc)
  );
`else
  logic unused_trace;
  assign unused_trace = ^{trace_idx, trace_clr, trace_we};
  assign trace_pc     = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: expected run outcomes are queued at
// start and compared when done rises.
module tb_cpu_run_ctrl;

  localparam int unsigned PC_W           = 32;
  localparam int unsigned RST_CYCLES     = 40;
  localparam int unsigned STALL_CYCLES   = 8;
  localparam int unsigned TIMEOUT_CYCLES = 500;
  localparam int unsigned TRACE_DEPTH    = 8;
  localparam int unsigned IDX_W          = 3;
  localparam logic [31:0] HALT_PC        = 32'h0000_0100;
  localparam int          NEVER          = 100000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             clear;
  logic [PC_W-1:0]  ext_pc;
  logic             core_rst_n;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [31:0]      cycle_cnt;
  logic [IDX_W-1:0] trace_idx;
  logic [PC_W-1:0]  trace_pc;

  typedef struct {
    logic        pass;
    logic        tmo;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  cpu_run_ctrl #(
    .PC_W           (PC_W),
    .RST_CYCLES     (RST_CYCLES),
    .STALL_CYCLES   (STALL_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .HALT_PC        (HALT_PC),
    .TRACE_DEPTH    (TRACE_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .clear      (clear),
    .ext_pc     (ext_pc),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .cycle_cnt  (cycle_cnt),
    .trace_idx  (trace_idx),
    .trace_pc   (trace_pc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run: PC = 4*k for RUN cycle k < hold_at, then hold_pc forever.
  task automatic do_run(input int hold_at, input logic [31:0] hold_pc,
                        input int abort_at, input int start_at);
    int   n;
    int   k;
    bit   seen;
    exp_t e;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_core_low", 32'(core_rst_n), 32'd0);
    n = 1;
    while (!core_rst_n && n < 100) begin
      tick();
      n++;
    end
    check_eq("reset_len", 32'(n), 32'(RST_CYCLES + 1));

    if (abort_at < 0) begin
      if (hold_at + int'(STALL_CYCLES) <= int'(TIMEOUT_CYCLES) - 1) begin
        e.pass = (hold_pc == HALT_PC);
        e.tmo  = 1'b0;
        e.cyc  = 32'(hold_at + int'(STALL_CYCLES));
      end else begin
        e.pass = 1'b0;
        e.tmo  = 1'b1;
        e.cyc  = 32'(TIMEOUT_CYCLES - 1);
      end
      sb_q.push_back(e);
    end

    k    = 0;
    seen = 1'b0;
    while (!seen && k < 700) begin
      ext_pc = (k < hold_at) ? 32'(4 * k) : hold_pc;
      start  = (k == start_at);
      if (k == abort_at) begin
        check_eq("abort_pre_cnt", cycle_cnt, 32'(k));
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_core_low", 32'(core_rst_n), 32'd0);
        check_eq("abort_cnt_zero", cycle_cnt, 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        return;
      end
      tick();
      start = 1'b0;
      if (done) seen = 1'b1;
      k++;
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
    if (seen && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("run_pass", 32'(pass), 32'(e.pass));
      check_eq("run_timeout", 32'(timeout), 32'(e.tmo));
      check_eq("run_cycles", cycle_cnt, e.cyc);
      repeat (3) tick();
      check_eq("frozen_cycles", cycle_cnt, e.cyc);
      check_eq("end_core_high", 32'(core_rst_n), 32'd1);
      check_eq("end_not_busy", 32'(busy), 32'd0);
      check_eq("end_done", 32'(done), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    clear     = 1'b0;
    ext_pc    = '0;
    trace_idx = '0;
    repeat (3) tick();
    check_eq("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check_eq("rst_cycle_cnt", cycle_cnt, 32'd0);
    rst_n = 1'b1;
    repeat (8) tick();
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_done", 32'(done), 32'd0);
    check_eq("idle_pass", 32'(pass), 32'd0);
    check_eq("idle_timeout", 32'(timeout), 32'd0);
    check_eq("idle_core_low", 32'(core_rst_n), 32'd0);
    check_eq("idle_trace_pc", trace_pc, 32'd0);

    // Pass with a stray start mid-run that must be ignored.
    do_run(64, 32'h100, -1, 20);
    // Fail-halt at a non-halt address.
    do_run(0, 32'h0C4, -1, -1);
    // Endless PC walk ends in timeout.
    do_run(NEVER, 32'h0, -1, -1);
    // Halt and timeout land on the same cycle: halt wins.
    do_run(491, 32'h100, -1, -1);
    // One cycle later the timeout comes first.
    do_run(492, 32'h100, -1, -1);
    // Async reset mid-run, then a full rerun from IDLE.
    do_run(NEVER, 32'h0, 150, -1);
    check_eq("post_abort_idle", 32'(busy), 32'd0);
    do_run(64, 32'h100, -1, -1);

    // clear beats a simultaneous start.
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    check_eq("clr_busy", 32'(busy), 32'd0);
    check_eq("clr_done", 32'(done), 32'd0);
    check_eq("clr_core_low", 32'(core_rst_n), 32'd0);
    check_eq("clr_pass", 32'(pass), 32'd0);
    check_eq("clr_cycles", cycle_cnt, 32'd0);
    repeat (3) tick();
    check_eq("clr_stays_idle", 32'(busy), 32'd0);

    // clear during RUN returns to IDLE.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (RST_CYCLES + 5) tick();
    check_eq("run_before_clr", 32'(core_rst_n), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("run_clr_core_low", 32'(core_rst_n), 32'd0);
    check_eq("run_clr_busy", 32'(busy), 32'd0);

    // Twelve distinct PCs 0x00..0x2C, then a self-loop.
    do_run(11, 32'h2C, -1, -1);
`ifdef RUN_CTRL_PC_TRACE_EN
    trace_idx = 3'd0;
    repeat (2) tick();
    check_eq("trace_newest", trace_pc, 32'h2C);
    trace_idx = 3'd7;
    repeat (2) tick();
    check_eq("trace_oldest", trace_pc, 32'h10);
`else
    trace_idx = 3'd5;
    repeat (2) tick();
    check_eq("trace_tied_zero", trace_pc, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
